trap_unit: RTL and testbench
============================

# trap_unit

Machine-mode trap controller at the consuming end of the history file's recovery/exception interface. It takes the kill request, tracks the recovery window, and captures the exception report (mepc/mcause/mtval) into its CSRs. It then redirects fetch to the trap vector, and handles `mret` back to mepc. It also owns the small machine CSR set that software reads and writes through the execute-stage CSR port.

## Interface
- `TRAP_VEC_RESET`, 32'h0000_0100: reset value of mtvec.
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `kill_instr_i` in 1: history file found a faulting head; recovery starts.
- `kill_pc_i` in 32: PC of the faulting instruction; informational, latched into `last_kill_pc`.
- `exc_occured_i` in 1: one-cycle pulse at the end of recovery; the exception fields below are valid.
- `exc_mepc_i` in 32: faulting PC.
- `exc_mcause_i` in 32: cause code.
- `exc_mtval_i` in 32: miss address / trap value.
- `mret_i` in 1: `mret` retiring from execute.
- `csr_addr_i` in 12: CSR address.
- `csr_wr_en_i` in 1: CSR write strobe.
- `csr_wr_data_i` in 32: CSR write data.
- `csr_rd_data_o` out 32: combinational read of `csr_addr_i`.
- `redirect_o` out 1: one-cycle fetch redirect.
- `redirect_pc_o` out 32: redirect target; valid when `redirect_o` is high.
- `flush_o` out 1: one-cycle pipeline flush.
- `stall_fetch_o` out 1: fetch hold while recovery is in flight.

## Operation
- CSRs (all reset to 0 except mtvec):
  - mstatus 0x300: only MIE bit 3 and MPIE bit 7 are stored; all other bits read 0.
  - mtvec 0x305: bits [1:0] forced 0; direct mode only.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: bits [1:0] forced 0.
  - mcause 0x342: full 32 bits.
  - mtval 0x343: full 32 bits.
  - mtrapcnt 0x7C0: 32-bit trap counter; wraps 0xFFFF_FFFF to 0; writable.
- Unmapped address: reads 0, writes dropped.
- FSM states: IDLE, RECOVER, REDIRECT.
- IDLE:
  - `kill_instr_i` → RECOVER; latch `kill_pc_i`.
  - `exc_occured_i` without a prior kill → trap capture → REDIRECT.
  - `mret_i` → MIE←MPIE, MPIE←1, target←mepc → REDIRECT.
- RECOVER:
  - `stall_fetch_o`=1.
  - CSR writes dropped.
  - `kill_instr_i` and `mret_i` ignored.
  - `exc_occured_i` → trap capture → REDIRECT.
- Trap capture (all in one clock edge):
  - mepc←`exc_mepc_i`&~3; mcause←`exc_mcause_i`; mtval←`exc_mtval_i`.
  - MPIE←MIE; MIE←0; mtrapcnt+1.
  - target←mtvec.
- REDIRECT: `redirect_o`=1 and `redirect_pc_o`=target for exactly this cycle, then → IDLE. All inputs are ignored in REDIRECT.
- Priority in IDLE: `exc_occured_i` > `kill_instr_i` > `mret_i`. Lower-priority events in the same cycle are dropped.
- Same-cycle CSR write and trap capture to mepc/mcause/mtval/mstatus/mtrapcnt: capture wins. Writes to other CSRs still commit.
- `csr_rd_data_o` returns the pre-edge register value; no same-cycle bypass of a write.
- Reset in any state → IDLE immediately on that edge. CSRs return to reset values and any pending redirect is discarded.

## Timing
- All outputs are registered except `csr_rd_data_o`.
- Reset values: `redirect_o`=0, `redirect_pc_o`=0, `flush_o`=0, `stall_fetch_o`=0.
- `flush_o` is high in the cycle after `kill_instr_i` is sampled in IDLE, for one cycle.
- `stall_fetch_o` is high every cycle the FSM is in RECOVER.
- Trap latency: `exc_occured_i` sampled at edge N → `redirect_o` high during cycle N+1.
- `mret` latency: `mret_i` at edge N → `redirect_o` high during cycle N+1.
- The history file asserts `exc_occured_i` one cycle after its last recovery write. There is no timeout: RECOVER is held indefinitely until `exc_occured_i`.
- Back-to-back traps are allowed. An event arriving the cycle after REDIRECT is accepted normally.

## Test plan
- Reset:
  - Stimulus: hold `rst_i` 2 cycles.
  - Required: all outputs 0; mtvec reads 0x100; mtrapcnt reads 0.
- Full trap flow:
  - Stimulus: write MIE=1. Pulse kill with `kill_pc_i`=0x40. Hold 5 cycles. Pulse `exc_occured_i` with mepc=0x43, mcause=2, mtval=0x40.
  - Required: `flush_o` for 1 cycle; `stall_fetch_o` for 5 cycles.
  - Required, next cycle after the exception pulse: `redirect_o`=1, `redirect_pc_o`=0x100.
  - Required CSRs: mepc=0x40, mcause=2, mtval=0x40, mstatus=0x80, mtrapcnt=1.
- `mret`:
  - Stimulus: after the trap above, assert `mret_i`.
  - Required: `redirect_pc_o`=0x40 the next cycle; mstatus reads 0x88.
- Collisions:
  - Stimulus A: kill and `mret_i` in the same cycle. Required: RECOVER entered; no `mret` redirect.
  - Stimulus B: CSR write mepc=0x200 in the same cycle as `exc_occured_i`. Required: mepc=trap value.
- CSR rules:
  - Stimulus: write mtvec=0x1003; write mtrapcnt=0xFFFFFFFF; take one trap.
  - Required: redirect to 0x1000; mtrapcnt=0.
  - Stimulus: write then read 0x7FF. Required: reads 0.
- Reset mid-recovery:
  - Stimulus: assert `rst_i` while in RECOVER; later pulse `exc_occured_i`.
  - Required: FSM back in IDLE; the later pulse traps normally.

Source files
------------

// File: rtl/trap_unit.sv
// Machine-mode trap controller: recovery window tracking, exception capture into
// machine CSRs, fetch redirect to mtvec on a trap and to mepc on mret.
module trap_unit #(
  parameter logic [31:0] TRAP_VEC_RESET = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        kill_instr_i,
  input  logic [31:0] kill_pc_i,
  input  logic        exc_occured_i,
  input  logic [31:0] exc_mepc_i,
  input  logic [31:0] exc_mcause_i,
  input  logic [31:0] exc_mtval_i,
  input  logic        mret_i,
  input  logic [11:0] csr_addr_i,
  input  logic        csr_wr_en_i,
  input  logic [31:0] csr_wr_data_i,
  output logic [31:0] csr_rd_data_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        stall_fetch_o
);

  localparam logic [11:0] CsrMstatus  = 12'h300;
  localparam logic [11:0] CsrMtvec    = 12'h305;
  localparam logic [11:0] CsrMscratch = 12'h340;
  localparam logic [11:0] CsrMepc     = 12'h341;
  localparam logic [11:0] CsrMcause   = 12'h342;
  localparam logic [11:0] CsrMtval    = 12'h343;
  localparam logic [11:0] CsrMtrapcnt = 12'h7C0;

  typedef enum logic [1:0] {
    StIdle,
    StRecover,
    StRedirect
  } state_e;

  state_e      state_q, state_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mtrapcnt_q, mtrapcnt_d;
  logic [31:0] last_kill_pc_q, last_kill_pc_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        flush_q, flush_d;
  logic        stall_q, stall_d;

  logic        capture;
  logic        do_mret;
  logic        csr_we_ok;

  always_comb begin
    state_d        = state_q;
    mie_d          = mie_q;
    mpie_d         = mpie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mtrapcnt_d     = mtrapcnt_q;
    last_kill_pc_d = last_kill_pc_q;
    redirect_d     = 1'b0;
    redirect_pc_d  = redirect_pc_q;
    flush_d        = 1'b0;
    capture        = 1'b0;
    do_mret        = 1'b0;
    csr_we_ok      = 1'b0;

    case (state_q)
      StIdle: begin
        csr_we_ok = 1'b1;
        if (exc_occured_i) begin
          capture = 1'b1;
        end else if (kill_instr_i) begin
          state_d        = StRecover;
          last_kill_pc_d = kill_pc_i;
          flush_d        = 1'b1;
        end else if (mret_i) begin
          do_mret = 1'b1;
        end
      end
      StRecover: begin
        if (exc_occured_i) begin
          capture = 1'b1;
        end
      end
      StRedirect: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Software writes land first so that same-cycle trap/mret updates override them.
    if (csr_we_ok && csr_wr_en_i) begin
      case (csr_addr_i)
        CsrMstatus: begin
          mie_d  = csr_wr_data_i[3];
          mpie_d = csr_wr_data_i[7];
        end
        CsrMtvec:    mtvec_d    = {csr_wr_data_i[31:2], 2'b00};
        CsrMscratch: mscratch_d = csr_wr_data_i;
        CsrMepc:     mepc_d     = {csr_wr_data_i[31:2], 2'b00};
        CsrMcause:   mcause_d   = csr_wr_data_i;
        CsrMtval:    mtval_d    = csr_wr_data_i;
        CsrMtrapcnt: mtrapcnt_d = csr_wr_data_i;
        default: ;
      endcase
    end

    if (capture) begin
      mepc_d        = {exc_mepc_i[31:2], 2'b00};
      mcause_d      = exc_mcause_i;
      mtval_d       = exc_mtval_i;
      mpie_d        = mie_q;
      mie_d         = 1'b0;
      mtrapcnt_d    = mtrapcnt_q + 32'd1;
      redirect_d    = 1'b1;
      redirect_pc_d = mtvec_q;
      state_d       = StRedirect;
    end

    if (do_mret) begin
      mie_d         = mpie_q;
      mpie_d        = 1'b1;
      redirect_d    = 1'b1;
      redirect_pc_d = mepc_q;
      state_d       = StRedirect;
    end

    stall_d = (state_d == StRecover);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      mie_q          <= 1'b0;
      mpie_q         <= 1'b0;
      mtvec_q        <= {TRAP_VEC_RESET[31:2], 2'b00};
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mtrapcnt_q     <= '0;
      last_kill_pc_q <= '0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= '0;
      flush_q        <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      mie_q          <= mie_d;
      mpie_q         <= mpie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mtrapcnt_q     <= mtrapcnt_d;
      last_kill_pc_q <= last_kill_pc_d;
      redirect_q     <= redirect_d;
      redirect_pc_q  <= redirect_pc_d;
      flush_q        <= flush_d;
      stall_q        <= stall_d;
    end
  end

  always_comb begin
    csr_rd_data_o = '0;
    case (csr_addr_i)
      CsrMstatus:  csr_rd_data_o = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
      CsrMtvec:    csr_rd_data_o = mtvec_q;
      CsrMscratch: csr_rd_data_o = mscratch_q;
      CsrMepc:     csr_rd_data_o = mepc_q;
      CsrMcause:   csr_rd_data_o = mcause_q;
      CsrMtval:    csr_rd_data_o = mtval_q;
      CsrMtrapcnt: csr_rd_data_o = mtrapcnt_q;
      default:     csr_rd_data_o = '0;
    endcase
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign flush_o       = flush_q;
  assign stall_fetch_o = stall_q;

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: redirect scoreboard plus directed CSR/FSM checks.
module tb_trap_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        kill_instr_i;
  logic [31:0] kill_pc_i;
  logic        exc_occured_i;
  logic [31:0] exc_mepc_i;
  logic [31:0] exc_mcause_i;
  logic [31:0] exc_mtval_i;
  logic        mret_i;
  logic [11:0] csr_addr_i;
  logic        csr_wr_en_i;
  logic [31:0] csr_wr_data_i;
  logic [31:0] csr_rd_data_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic        stall_fetch_o;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } redir_t;

  redir_t sb[$];
  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;

  trap_unit dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .kill_instr_i  (kill_instr_i),
    .kill_pc_i     (kill_pc_i),
    .exc_occured_i (exc_occured_i),
    .exc_mepc_i    (exc_mepc_i),
    .exc_mcause_i  (exc_mcause_i),
    .exc_mtval_i   (exc_mtval_i),
    .mret_i        (mret_i),
    .csr_addr_i    (csr_addr_i),
    .csr_wr_en_i   (csr_wr_en_i),
    .csr_wr_data_i (csr_wr_data_i),
    .csr_rd_data_o (csr_rd_data_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .flush_o       (flush_o),
    .stall_fetch_o (stall_fetch_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr_i = addr;
    #1;
    check(tag, csr_rd_data_o, exp);
  endtask

  // Called just after a negedge; the write is sampled on the following posedge.
  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    csr_addr_i    = addr;
    csr_wr_data_i = data;
    csr_wr_en_i   = 1'b1;
    @(negedge clk);
    csr_wr_en_i   = 1'b0;
  endtask

  task automatic expect_redirect(input logic [31:0] pc);
    sb.push_back('{pc: pc, cyc: cyc + 1});
  endtask

  task automatic set_exc(input logic [31:0] epc, input logic [31:0] cause,
                         input logic [31:0] tval);
    exc_occured_i = 1'b1;
    exc_mepc_i    = epc;
    exc_mcause_i  = cause;
    exc_mtval_i   = tval;
  endtask

  always @(negedge clk) begin
    if (redirect_o) begin
      if (sb.size() == 0) begin
        check("unexpected_redirect", 32'd1, 32'd0);
      end else begin
        redir_t e;
        e = sb.pop_front();
        check("redirect_pc", redirect_pc_o, e.pc);
        check("redirect_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    kill_instr_i = 1'b0;
    kill_pc_i = '0;
    exc_occured_i = 1'b0;
    exc_mepc_i = '0;
    exc_mcause_i = '0;
    exc_mtval_i = '0;
    mret_i = 1'b0;
    csr_addr_i = '0;
    csr_wr_en_i = 1'b0;
    csr_wr_data_i = '0;

    // Reset
    repeat (2) @(negedge clk);
    check("rst_redirect", {31'd0, redirect_o}, 32'd0);
    check("rst_redirect_pc", redirect_pc_o, 32'd0);
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check("rst_stall", {31'd0, stall_fetch_o}, 32'd0);
    chk_csr("rst_mtvec", 12'h305, 32'h100);
    chk_csr("rst_mtrapcnt", 12'h7C0, 32'd0);
    chk_csr("rst_mstatus", 12'h300, 32'd0);
    rst_i = 1'b0;

    // Full trap flow
    @(negedge clk);
    wr(12'h300, 32'h8);
    chk_csr("mstatus_mie", 12'h300, 32'h8);
    kill_instr_i = 1'b1;
    kill_pc_i = 32'h40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      kill_instr_i = 1'b0;
      check($sformatf("flush_c%0d", i), {31'd0, flush_o}, (i == 0) ? 32'd1 : 32'd0);
      check($sformatf("stall_c%0d", i), {31'd0, stall_fetch_o}, 32'd1);
      if (i == 1) begin
        csr_addr_i = 12'h340;
        csr_wr_data_i = 32'hDEAD;
        csr_wr_en_i = 1'b1;
      end else begin
        csr_wr_en_i = 1'b0;
      end
      if (i == 4) begin
        set_exc(32'h43, 32'd2, 32'h40);
        expect_redirect(32'h100);
      end
    end
    @(negedge clk);
    exc_occured_i = 1'b0;
    check("stall_after_trap", {31'd0, stall_fetch_o}, 32'd0);
    chk_csr("trap_mepc", 12'h341, 32'h40);
    chk_csr("trap_mcause", 12'h342, 32'd2);
    chk_csr("trap_mtval", 12'h343, 32'h40);
    chk_csr("trap_mstatus", 12'h300, 32'h80);
    chk_csr("trap_mtrapcnt", 12'h7C0, 32'd1);
    chk_csr("recover_wr_dropped", 12'h340, 32'd0);

    // mret
    @(negedge clk);
    mret_i = 1'b1;
    expect_redirect(32'h40);
    @(negedge clk);
    mret_i = 1'b0;
    chk_csr("mret_mstatus", 12'h300, 32'h88);

    // Collision A: kill with mret enters recovery, mret dropped
    @(negedge clk);
    kill_instr_i = 1'b1;
    kill_pc_i = 32'h80;
    mret_i = 1'b1;
    @(negedge clk);
    kill_instr_i = 1'b0;
    mret_i = 1'b0;
    check("collA_flush", {31'd0, flush_o}, 32'd1);
    check("collA_stall", {31'd0, stall_fetch_o}, 32'd1);
    @(negedge clk);
    mret_i = 1'b1;
    @(negedge clk);
    mret_i = 1'b0;
    check("collA_stall_held", {31'd0, stall_fetch_o}, 32'd1);
    set_exc(32'h87, 32'd5, 32'h1234);
    expect_redirect(32'h100);
    @(negedge clk);
    exc_occured_i = 1'b0;
    chk_csr("collA_mepc", 12'h341, 32'h84);
    chk_csr("collA_mtrapcnt", 12'h7C0, 32'd2);

    // Collision B: mepc write loses to capture
    @(negedge clk);
    set_exc(32'h90, 32'd7, 32'h55);
    expect_redirect(32'h100);
    csr_addr_i = 12'h341;
    csr_wr_data_i = 32'h200;
    csr_wr_en_i = 1'b1;
    @(negedge clk);
    exc_occured_i = 1'b0;
    csr_wr_en_i = 1'b0;
    chk_csr("collB_mepc", 12'h341, 32'h90);
    chk_csr("collB_mtrapcnt", 12'h7C0, 32'd3);

    // Back-to-back trap with same-cycle kill (dropped) and mscratch write (commits)
    @(negedge clk);
    set_exc(32'hA0, 32'd11, 32'h66);
    kill_instr_i = 1'b1;
    expect_redirect(32'h100);
    csr_addr_i = 12'h340;
    csr_wr_data_i = 32'h55;
    csr_wr_en_i = 1'b1;
    @(negedge clk);
    exc_occured_i = 1'b0;
    kill_instr_i = 1'b0;
    csr_wr_en_i = 1'b0;
    check("prio_no_flush", {31'd0, flush_o}, 32'd0);
    check("prio_no_stall", {31'd0, stall_fetch_o}, 32'd0);
    chk_csr("other_csr_commits", 12'h340, 32'h55);
    chk_csr("b2b_mcause", 12'h342, 32'd11);

    // CSR rules
    @(negedge clk);
    wr(12'h305, 32'h1003);
    wr(12'h7C0, 32'hFFFF_FFFF);
    chk_csr("mtvec_align", 12'h305, 32'h1000);
    wr(12'h300, 32'hFFFF_FFFF);
    chk_csr("mstatus_mask", 12'h300, 32'h88);
    set_exc(32'hC0, 32'd1, 32'h0);
    expect_redirect(32'h1000);
    @(negedge clk);
    exc_occured_i = 1'b0;
    chk_csr("mtrapcnt_wrap", 12'h7C0, 32'd0);
    @(negedge clk);
    wr(12'h7FF, 32'hFFFF);
    chk_csr("unmapped_read", 12'h7FF, 32'd0);

    // Reset mid-recovery
    kill_instr_i = 1'b1;
    kill_pc_i = 32'h300;
    @(negedge clk);
    kill_instr_i = 1'b0;
    check("pre_rst_stall", {31'd0, stall_fetch_o}, 32'd1);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("midrst_stall", {31'd0, stall_fetch_o}, 32'd0);
    check("midrst_flush", {31'd0, flush_o}, 32'd0);
    chk_csr("midrst_mtvec", 12'h305, 32'h100);
    chk_csr("midrst_mtrapcnt", 12'h7C0, 32'd0);
    @(negedge clk);
    set_exc(32'hE4, 32'd3, 32'h9);
    expect_redirect(32'h100);
    @(negedge clk);
    exc_occured_i = 1'b0;
    check("post_rst_stall", {31'd0, stall_fetch_o}, 32'd0);
    chk_csr("post_rst_mtrapcnt", 12'h7C0, 32'd1);
    chk_csr("post_rst_mepc", 12'h341, 32'hE4);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
